// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM unified-memory arbiter.
// Imported by the arbiter, its interface users and the stall counter.
package cpu_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic MEM_WE_READ = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_D,
        BUSY_I
    } arbState_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline (IF and MEM stages), the arbiter
// and the unified memory; the arbiter takes the slave view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = cpu_mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = cpu_mem_pkg::DEF_DATA_W
);

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;

    logic              dm_read_i;
    logic              dm_write_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_rdata_o,
        input  dm_read_i, dm_write_i, dm_addr_i, dm_wdata_i,
        output dm_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_rdata_o,
        output dm_read_i, dm_write_i, dm_addr_i, dm_wdata_i,
        input  dm_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_port_arbiter_stall_counter.sv
// Free-running wrap-around counter of pipeline stall cycles.
// Cleared asynchronously with the rest of the core.
module stall_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // Count every enabled cycle, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one memory port,
// freezing the pipeline until every access of the cycle is done.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    mem_port_arbiter_if.slave bus,
    output logic             stall_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    arbState_t         state;
    logic              ifDone;
    logic              dmDone;
    logic              dmReq;
    logic              stall;
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] ifRdata;
    logic [DATA_W-1:0] dmRdata;

    assign dmReq = bus.dm_read_i | bus.dm_write_i;

    // Freeze while any requester of this cycle is still unserved.
    assign stall = rst_i & start_i
                 & ((bus.if_req_i & ~ifDone) | (dmReq & ~dmDone));

    assign stall_o         = stall;
    assign bus.mem_req_o   = memReq;
    assign bus.mem_we_o    = memWe;
    assign bus.mem_addr_o  = memAddr;
    assign bus.mem_wdata_o = memWdata;
    assign bus.if_rdata_o  = ifRdata;
    assign bus.dm_rdata_o  = dmRdata;

    // Arbitration FSM; data wins because it belongs to the older instruction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            ifRdata  <= '0;
            dmRdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i && dmReq && !dmDone) begin
                        state    <= BUSY_D;
                        memReq   <= 1'b1;
                        memWe    <= bus.dm_write_i;
                        memAddr  <= bus.dm_addr_i;
                        memWdata <= bus.dm_wdata_i;
                    end else if (start_i && bus.if_req_i && !ifDone) begin
                        state    <= BUSY_I;
                        memReq   <= 1'b1;
                        memWe    <= MEM_WE_READ;
                        memAddr  <= bus.if_addr_i;
                        memWdata <= '0;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ack_i) begin
                        state    <= IDLE;
                        memReq   <= 1'b0;
                        memWe    <= 1'b0;
                        memAddr  <= '0;
                        memWdata <= '0;
                        if (!memWe) begin
                            dmRdata <= bus.mem_rdata_i;
                        end
                    end
                end
                BUSY_I: begin
                    if (bus.mem_ack_i) begin
                        state    <= IDLE;
                        memReq   <= 1'b0;
                        memWe    <= 1'b0;
                        memAddr  <= '0;
                        memWdata <= '0;
                        ifRdata  <= bus.mem_rdata_i;
                    end
                end
                default: begin
                    state    <= IDLE;
                    memReq   <= 1'b0;
                    memWe    <= 1'b0;
                    memAddr  <= '0;
                    memWdata <= '0;
                end
            endcase
        end
    end

    // Done flags remember served requesters until the pipeline advances.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ifDone <= 1'b0;
            dmDone <= 1'b0;
        end else if (!stall) begin
            ifDone <= 1'b0;
            dmDone <= 1'b0;
        end else if (bus.mem_ack_i) begin
            if (state == BUSY_D) begin
                dmDone <= 1'b1;
            end
            if (state == BUSY_I) begin
                ifDone <= 1'b1;
            end
        end
    end

    stall_counter #(
        .CNT_W (CNT_W)
    ) u_stallCounter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (stall),
        .cnt   (stall_cnt_o)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: CPU-level reference memory,
// randomized memory latency and spurious acks.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          start = 1'b0;
    logic          stall;
    logic [CW-1:0] stallCnt;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rstN),
        .start_i     (start),
        .bus         (bus),
        .stall_o     (stall),
        .stall_cnt_o (stallCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } memExp_t;

    typedef struct {
        int            stallCycles;
        logic [DW-1:0] ifData;
        logic [DW-1:0] dmData;
        logic [CW-1:0] cnt;
    } opExp_t;

    memExp_t memQ[$];
    int      waitQ[$];
    opExp_t  opQ[$];
    memExp_t preloadQ[$];

    logic [DW-1:0] physMem[logic [AW-1:0]];
    logic [DW-1:0] refMem[logic [AW-1:0]];

    logic [DW-1:0] expIf = '0;
    logic [DW-1:0] expDm = '0;
    logic [CW-1:0] expCnt = '0;

    int checks = 0;
    int failures = 0;

    bit            manualMem = 1'b1;
    bit            manualAck = 1'b0;
    logic [DW-1:0] manualRdata = '0;

    bit      rspActive = 1'b0;
    int      rspRemaining = 0;
    memExp_t rspCur;
    memExp_t rspExp;
    memExp_t pl;
    opExp_t  monOp;
    int      runLen = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] defWord(logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [DW-1:0] readRef(logic [AW-1:0] a);
        return refMem.exists(a) ? refMem[a] : defWord(a);
    endfunction

    function automatic logic [DW-1:0] readPhys(logic [AW-1:0] a);
        return physMem.exists(a) ? physMem[a] : defWord(a);
    endfunction

    // Memory model: random latency, stability checks, spurious acks.
    initial begin : responder
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            while (preloadQ.size() > 0) begin
                pl = preloadQ.pop_front();
                physMem[pl.addr] = pl.wdata;
            end
            if (manualMem) begin
                rspActive       = 1'b0;
                bus.mem_ack_i   = manualAck;
                bus.mem_rdata_i = manualRdata;
                continue;
            end
            bus.mem_ack_i = 1'b0;
            if (bus.mem_req_o) begin
                if (!rspActive) begin
                    rspActive    = 1'b1;
                    rspCur.addr  = bus.mem_addr_o;
                    rspCur.we    = bus.mem_we_o;
                    rspCur.wdata = bus.mem_wdata_o;
                    if (memQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL memReqUnexpected: got addr 0x%0h want none",
                                 rspCur.addr);
                        rspRemaining = 0;
                    end else begin
                        rspExp       = memQ.pop_front();
                        rspRemaining = waitQ.pop_front();
                        chk("memAddr", rspCur.addr, rspExp.addr);
                        chk("memWe", rspCur.we, rspExp.we);
                        if (rspExp.we) begin
                            chk("memWdata", rspCur.wdata, rspExp.wdata);
                        end
                    end
                end else begin
                    chk("memAddrStable", bus.mem_addr_o, rspCur.addr);
                    chk("memWeStable", bus.mem_we_o, rspCur.we);
                    chk("memWdataStable", bus.mem_wdata_o, rspCur.wdata);
                end
                if (rspRemaining == 0) begin
                    bus.mem_ack_i = 1'b1;
                    if (rspCur.we) begin
                        physMem[rspCur.addr] = rspCur.wdata;
                        bus.mem_rdata_i = $urandom;
                    end else begin
                        bus.mem_rdata_i = readPhys(rspCur.addr);
                    end
                    rspActive = 1'b0;
                end else begin
                    rspRemaining--;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = $urandom;
            end
        end
    end

    // Scoreboard monitor: each non-stalled cycle retires one pushed op.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (stall) begin
                runLen++;
            end else begin
                if (opQ.size() > 0) begin
                    monOp = opQ.pop_front();
                    chk("stallCycles", runLen, monOp.stallCycles);
                    chk("ifRdata", bus.if_rdata_o, monOp.ifData);
                    chk("dmRdata", bus.dm_rdata_o, monOp.dmData);
                    chk("stallCnt", stallCnt, monOp.cnt);
                end
                runLen = 0;
            end
        end
    end

    task automatic preload(logic [AW-1:0] a, logic [DW-1:0] d);
        memExp_t m;
        m.addr  = a;
        m.we    = 1'b1;
        m.wdata = d;
        preloadQ.push_back(m);
        refMem[a] = d;
    endtask

    // Reference model: data access first, then fetch; 2+wait stall each.
    task automatic issue(bit st, bit ir, logic [AW-1:0] ia,
                         bit rd, bit wr, logic [AW-1:0] da,
                         logic [DW-1:0] wd, int wD, int wI);
        opExp_t  e;
        memExp_t m;
        int      s = 0;
        if (st && (rd || wr)) begin
            m.addr  = da;
            m.we    = wr;
            m.wdata = wd;
            memQ.push_back(m);
            waitQ.push_back(wD);
            s += 2 + wD;
            if (wr) refMem[da] = wd;
            else    expDm = readRef(da);
        end
        if (st && ir) begin
            m.addr  = ia;
            m.we    = 1'b0;
            m.wdata = '0;
            memQ.push_back(m);
            waitQ.push_back(wI);
            s += 2 + wI;
            expIf = readRef(ia);
        end
        expCnt        = expCnt + CW'(s);
        e.stallCycles = s;
        e.ifData      = expIf;
        e.dmData      = expDm;
        e.cnt         = expCnt;
        opQ.push_back(e);
        start          = st;
        bus.if_req_i   = ir;
        bus.if_addr_i  = ia;
        bus.dm_read_i  = rd;
        bus.dm_write_i = wr;
        bus.dm_addr_i  = da;
        bus.dm_wdata_i = wd;
    endtask

    task automatic runOp(bit st, bit ir, logic [AW-1:0] ia,
                         bit rd, bit wr, logic [AW-1:0] da,
                         logic [DW-1:0] wd, int wD, int wI);
        int guard = 0;
        issue(st, ir, ia, rd, wr, da, wd, wD, wI);
        do begin
            @(negedge clk);
            guard++;
        end while (stall && guard < 100);
        if (stall) begin
            checks++;
            failures++;
            $display("FAIL opTimeout: got stall 1 want 0 within 100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : driver
        bit            st;
        bit            ir;
        bit            rd;
        bit            wr;
        int            k;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;

        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = '0;
        bus.dm_read_i  = 1'b0;
        bus.dm_write_i = 1'b0;
        bus.dm_addr_i  = '0;
        bus.dm_wdata_i = '0;

        preload(32'h0, 32'h0050_0093);
        preload(32'h40, 32'h0000_1234);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rstMemReq", bus.mem_req_o, 1'b0);
        chk("rstMemWe", bus.mem_we_o, 1'b0);
        chk("rstMemAddr", bus.mem_addr_o, 0);
        chk("rstMemWdata", bus.mem_wdata_o, 0);
        chk("rstIfRdata", bus.if_rdata_o, 0);
        chk("rstDmRdata", bus.dm_rdata_o, 0);
        chk("rstStall", stall, 1'b0);
        chk("rstCnt", stallCnt, 0);
        rstN = 1'b1;

        // Reset in the middle of a data transaction.
        @(posedge clk);
        #1;
        start         = 1'b1;
        bus.dm_read_i = 1'b1;
        bus.dm_addr_i = 32'h40;
        @(negedge clk);
        chk("midRstPreStall", stall, 1'b1);
        @(posedge clk);
        #1;
        chk("midRstBusyReq", bus.mem_req_o, 1'b1);
        chk("midRstBusyAddr", bus.mem_addr_o, 32'h40);
        #2;
        rstN = 1'b0;
        #1;
        chk("midRstReqDrop", bus.mem_req_o, 1'b0);
        chk("midRstStall", stall, 1'b0);
        chk("midRstCnt", stallCnt, 0);
        start         = 1'b0;
        bus.dm_read_i = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        manualAck   = 1'b1;
        manualRdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        manualAck = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lateAckReq", bus.mem_req_o, 1'b0);
        chk("lateAckDm", bus.dm_rdata_o, 0);
        chk("lateAckIf", bus.if_rdata_o, 0);
        chk("lateAckCnt", stallCnt, 0);
        manualMem = 1'b0;
        @(posedge clk);
        #1;

        runOp(1, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        runOp(1, 1, 32'h8, 1, 0, 32'h40, 32'h0, 0, 0);
        runOp(1, 0, 32'h0, 0, 1, 32'h10, 32'hDEAD_BEEF, 3, 0);
        for (int i = 0; i < 8; i++) begin
            runOp(0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        end
        runOp(1, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        runOp(1, 1, 32'h4, 0, 0, 32'h0, 32'h0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            st = ($urandom_range(0, 7) != 0);
            ir = ($urandom_range(0, 3) != 0);
            k  = $urandom_range(0, 7);
            rd = (k >= 1 && k <= 3) || k == 6;
            wr = (k == 4 || k == 5 || k == 6);
            ia = AW'($urandom_range(0, 15) * 4);
            da = AW'($urandom_range(0, 15) * 4);
            runOp(st, ir, ia, rd, wr, da, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        start          = 1'b0;
        bus.if_req_i   = 1'b0;
        bus.dm_read_i  = 1'b0;
        bus.dm_write_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("opQDrained", opQ.size(), 0);
        chk("memQDrained", memQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
